// File: rtl/ser_pkg.sv
// Shared types and constants for the result serializer.
// Optional feature macro: SER_CHECKSUM_EN (appends a checksum word to lane B).
package ser_pkg;

   // Default word width of every serialized word.
   localparam int unsigned DW = 16;

   // Final index of each lane.
   localparam logic [1:0] A_LAST = 2'd3;
   localparam logic [2:0] B_LAST = 3'd5;
   // Lane B final index when the checksum word is appended.
   localparam logic [2:0] B_CSUM = 3'd6;

   // Number of captured input words.
   localparam int unsigned NumWords = 10;

   // Top-level sequencing states.
   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDone
   } ser_state_e;

endpackage

// File: rtl/ser_lane.sv
// Generic valid/ready output lane. Walks an indexed word array from index 0 up
// to last_i, presenting one registered word at a time. Data and index only move
// on a transfer, so they stay stable under backpressure.
module ser_lane #(
   parameter int unsigned DW     = 16,
   parameter int unsigned SelW   = 2,
   parameter int unsigned NWords = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [NWords-1:0][DW-1:0]    words_i,
   input  logic [SelW-1:0]              last_i,
   input  logic                         ready_i,
   output logic                         valid_o,
   output logic [DW-1:0]                data_o,
   output logic [SelW-1:0]              sel_o,
   output logic                         last_xfer_o
);

   logic            valid_q, valid_d;
   logic [DW-1:0]   data_q, data_d;
   logic [SelW-1:0] sel_q, sel_d;
   logic [SelW-1:0] sel_nxt;
   logic            xfer;
   logic            at_last;

   // Next-state: start loads word 0, each transfer steps to the next index or
   // retires the lane after the last one.
   always_comb begin
      xfer    = valid_q & ready_i;
      at_last = (sel_q == last_i);
      sel_nxt = sel_q + SelW'(1);
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (start_i) begin
         valid_d = 1'b1;
         sel_d   = '0;
         data_d  = words_i[0];
      end else if (xfer) begin
         if (at_last) begin
            // Data and index hold their last values once the lane retires.
            valid_d = 1'b0;
         end else begin
            sel_d  = sel_nxt;
            data_d = words_i[sel_nxt];
         end
      end
   end

   // Lane output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   // Outputs are direct register values; last_xfer_o flags the final handshake.
   always_comb begin
      valid_o     = valid_q;
      data_o      = data_q;
      sel_o       = sel_q;
      last_xfer_o = xfer & at_last;
   end

endmodule

// File: rtl/result_serializer_16bit.sv
// Result serializer: snapshots ten words on a load pulse and streams W1..W4 on
// lane A and W5..W10 on lane B, each with valid/ready and a select index.
// Optional feature macro: SER_CHECKSUM_EN -- lane B appends the modulo-2^DW
// sum of all ten words with index 6.
module result_serializer_16bit
   import ser_pkg::*;
#(
   parameter int unsigned DW = ser_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] Data_in1,
   input  logic [DW-1:0] Data_in2,
   input  logic [DW-1:0] Data_in3,
   input  logic [DW-1:0] Data_in4,
   input  logic [DW-1:0] Data_in5,
   input  logic [DW-1:0] Data_in6,
   input  logic [DW-1:0] Data_in7,
   input  logic [DW-1:0] Data_in8,
   input  logic [DW-1:0] Data_in9,
   input  logic [DW-1:0] Data_in10,
   output logic          busy,
   output logic          a_valid,
   input  logic          a_ready,
   output logic [DW-1:0] a_data,
   output logic [1:0]    a_sel,
   output logic          b_valid,
   input  logic          b_ready,
   output logic [DW-1:0] b_data,
   output logic [2:0]    b_sel,
   output logic          done
);

`ifdef SER_CHECKSUM_EN
   localparam int unsigned BWords = 7;
   localparam logic [2:0]  BLastIdx = B_CSUM;
`else
   localparam int unsigned BWords = 6;
   localparam logic [2:0]  BLastIdx = B_LAST;
`endif

   ser_state_e state_q, state_d;

   logic [NumWords-1:0][DW-1:0] din;
   logic [NumWords-1:0][DW-1:0] snap_q;
   logic                        load_acc;

   logic [3:0][DW-1:0]          a_words;
   logic [BWords-1:0][DW-1:0]   b_words;
   logic [5:0][DW-1:0]          b_src;
   logic                        a_last_xfer;
   logic                        b_last_xfer;
   logic                        a_fin;
   logic                        b_fin;

   assign din = {Data_in10, Data_in9, Data_in8, Data_in7, Data_in6,
                 Data_in5,  Data_in4, Data_in3, Data_in2, Data_in1};

   // A load is only honoured from idle; loads while streaming or in the done
   // cycle are dropped without side effects.
   assign load_acc = (state_q == StIdle) & load;

   // Snapshot capture; frozen for the whole stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
      end else if (load_acc) begin
         snap_q <= din;
      end
   end

   // On the capture edge the snapshot is not yet written, so the lanes take
   // their first word straight from the inputs.
   always_comb begin
      a_words = load_acc ? din[3:0] : snap_q[3:0];
      b_src   = load_acc ? din[9:4] : snap_q[9:4];
   end

`ifdef SER_CHECKSUM_EN
   logic          capt_q;
   logic [DW-1:0] csum_q, csum_d;

   // Sum of the frozen snapshot, carries discarded.
   always_comb begin
      csum_d = '0;
      for (int i = 0; i < int'(NumWords); i++) begin
         csum_d = csum_d + snap_q[i];
      end
   end

   // Latch the checksum one cycle after capture, well before lane B can reach
   // index 6.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         capt_q <= 1'b0;
         csum_q <= '0;
      end else begin
         capt_q <= load_acc;
         if (capt_q) begin
            csum_q <= csum_d;
         end
      end
   end

   assign b_words = {csum_q, b_src};
`else
   assign b_words = b_src;
`endif

   ser_lane #(
      .DW     (DW),
      .SelW   (2),
      .NWords (4)
   ) u_lane_a (
      .clk         (clk),
      .rst         (rst),
      .start_i     (load_acc),
      .words_i     (a_words),
      .last_i      (A_LAST),
      .ready_i     (a_ready),
      .valid_o     (a_valid),
      .data_o      (a_data),
      .sel_o       (a_sel),
      .last_xfer_o (a_last_xfer)
   );

   ser_lane #(
      .DW     (DW),
      .SelW   (3),
      .NWords (BWords)
   ) u_lane_b (
      .clk         (clk),
      .rst         (rst),
      .start_i     (load_acc),
      .words_i     (b_words),
      .last_i      (BLastIdx),
      .ready_i     (b_ready),
      .valid_o     (b_valid),
      .data_o      (b_data),
      .sel_o       (b_sel),
      .last_xfer_o (b_last_xfer)
   );

   // A lane is finished once it has retired or retires on this edge. In
   // STREAM a low valid can only mean the lane already retired.
   assign a_fin = ~a_valid | a_last_xfer;
   assign b_fin = ~b_valid | b_last_xfer;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StStream;
            end
         end
         StStream: begin
            // Both lanes finishing on the same edge enter DONE only once.
            if (a_fin && b_fin) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (state_q == StStream);
      done = (state_q == StDone);
   end

endmodule
